// File: rtl/y86_regfile_writeback.sv
// Y86-64 write-back stage fused with the 15-entry architectural register file.
// Latency: destination decode, write data and reads are combinational; writes commit on the clk rising edge.
// Backpressure: none; wrEn gates commits and reEn gates the read ports.
module y86_regfile_writeback #(
  parameter int          NREG   = 15,
  parameter int          W      = 64,
  parameter logic [3:0]  RSP_ID = 4'h4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   opcode,
  input  logic [7:0]   rArB,
  input  logic         cnd,
  input  logic [W-1:0] valE,
  input  logic [W-1:0] valM,
  input  logic         wrEn,
  input  logic         reEn,
  input  logic [3:0]   registernumber1_read,
  input  logic [3:0]   registernumber2_read,
  output logic [3:0]   registernumber1,
  output logic [3:0]   registernumber2,
  output logic [W-1:0] val_write1,
  output logic [W-1:0] val_write2,
  output logic [W-1:0] val_read1,
  output logic [W-1:0] val_read2,
  output logic         regerr
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [3:0]   reg_a;
  logic [3:0]   reg_b;
  logic [3:0]   dst_e;
  logic [3:0]   dst_m;
  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];

  assign icode = opcode[7:4];
  assign ifun  = opcode[3:0];
  assign reg_a = rArB[7:4];
  assign reg_b = rArB[3:0];

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (icode)
      // ifun 0 is the unconditional rrmovq, which always writes.
      I_CMOVXX: dst_e = (cnd || (ifun == 4'h0)) ? reg_b : RNONE;
      I_IRMOVQ,
      I_OPQ:    dst_e = reg_b;
      I_MRMOVQ: dst_m = reg_a;
      I_CALL,
      I_RET,
      I_PUSHQ:  dst_e = RSP_ID;
      I_POPQ: begin
        dst_e = RSP_ID;
        dst_m = reg_a;
      end
      default: begin
        dst_e = RNONE;
        dst_m = RNONE;
      end
    endcase
  end

  assign registernumber1 = dst_e;
  assign registernumber2 = dst_m;
  assign val_write1      = valE;
  assign val_write2      = valM;

  // M-port is checked first so it wins when both ports target one register.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wrEn) begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_m == 4'(i)) begin
          regs_d[i] = valM;
        end else if (dst_e == 4'(i)) begin
          regs_d[i] = valE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    val_read1 = '0;
    val_read2 = '0;
    if (reEn) begin
      if ((registernumber1_read != RNONE) && (32'(registernumber1_read) < NREG)) begin
        val_read1 = regs_q[registernumber1_read];
      end
      if ((registernumber2_read != RNONE) && (32'(registernumber2_read) < NREG)) begin
        val_read2 = regs_q[registernumber2_read];
      end
    end
  end

  assign regerr = (icode > I_POPQ) ||
                  (reEn && ((registernumber1_read == RNONE) || (registernumber2_read == RNONE)));

endmodule

// File: tb/tb_y86_regfile_writeback.sv
// Directed bench for y86_regfile_writeback: vector table plus reset corner sequences.
module tb_y86_regfile_writeback;

  logic        clk;
  logic        reset;
  logic [7:0]  opcode;
  logic [7:0]  rArB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wrEn;
  logic        reEn;
  logic [3:0]  rd1;
  logic [3:0]  rd2;
  logic [3:0]  registernumber1;
  logic [3:0]  registernumber2;
  logic [63:0] val_write1;
  logic [63:0] val_write2;
  logic [63:0] val_read1;
  logic [63:0] val_read2;
  logic        regerr;

  int errors = 0;
  int checks = 0;

  y86_regfile_writeback dut (
    .clk                 (clk),
    .reset               (reset),
    .opcode              (opcode),
    .rArB                (rArB),
    .cnd                 (cnd),
    .valE                (valE),
    .valM                (valM),
    .wrEn                (wrEn),
    .reEn                (reEn),
    .registernumber1_read(rd1),
    .registernumber2_read(rd2),
    .registernumber1     (registernumber1),
    .registernumber2     (registernumber2),
    .val_write1          (val_write1),
    .val_write2          (val_write2),
    .val_read1           (val_read1),
    .val_read2           (val_read2),
    .regerr              (regerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  rarb;
    logic        c;
    logic [63:0] ve;
    logic [63:0] vm;
    logic        we;
    logic        re;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [3:0]  e_dste;
    logic [3:0]  e_dstm;
    logic        e_err;
    logic [63:0] e_pre1;
    logic [63:0] e_post1;
    logic [63:0] e_post2;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [7:0] op, logic [7:0] rarb, logic c, logic [63:0] ve,
                              logic [63:0] vm, logic we, logic re, logic [3:0] a1, logic [3:0] a2,
                              logic [3:0] e_dste, logic [3:0] e_dstm, logic e_err,
                              logic [63:0] e_pre1, logic [63:0] e_post1, logic [63:0] e_post2);
    vec_t v;
    v.op = op; v.rarb = rarb; v.c = c; v.ve = ve; v.vm = vm; v.we = we; v.re = re;
    v.a1 = a1; v.a2 = a2; v.e_dste = e_dste; v.e_dstm = e_dstm; v.e_err = e_err;
    v.e_pre1 = e_pre1; v.e_post1 = e_post1; v.e_post2 = e_post2;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Register state evolves in order through the table, starting from all zeros.
    //          op     rArB   c     valE      valM   we re a1 a2   dstE dstM err pre      post1    post2
    vecs[0]  = mk(8'hA0, 8'h30, 1'b0, 64'd1023, 64'd0,  1, 1, 4'h4, 4'h3, 4'h4, 4'hF, 0, 64'd0,    64'd1023, 64'd0);
    vecs[1]  = mk(8'h54, 8'h40, 1'b0, 64'd999,  64'd120,1, 1, 4'h4, 4'h0, 4'hF, 4'h4, 0, 64'd1023, 64'd120,  64'd0);
    vecs[2]  = mk(8'hB0, 8'h4F, 1'b0, 64'd8,    64'd77, 1, 1, 4'h4, 4'h0, 4'h4, 4'h4, 0, 64'd120,  64'd77,   64'd0);
    vecs[3]  = mk(8'h21, 8'h12, 1'b0, 64'd5,    64'd0,  1, 1, 4'h2, 4'h4, 4'hF, 4'hF, 0, 64'd0,    64'd0,    64'd77);
    vecs[4]  = mk(8'h21, 8'h12, 1'b1, 64'd5,    64'd0,  1, 1, 4'h2, 4'h4, 4'h2, 4'hF, 0, 64'd0,    64'd5,    64'd77);
    vecs[5]  = mk(8'h20, 8'h23, 1'b0, 64'd9,    64'd0,  1, 1, 4'h3, 4'h2, 4'h3, 4'hF, 0, 64'd0,    64'd9,    64'd5);
    vecs[6]  = mk(8'h30, 8'hF7, 1'b0, 64'h1234, 64'd0,  0, 1, 4'h7, 4'h3, 4'h7, 4'hF, 0, 64'd0,    64'd0,    64'd9);
    vecs[7]  = mk(8'h30, 8'hF7, 1'b0, 64'h1234, 64'd0,  1, 1, 4'h7, 4'h3, 4'h7, 4'hF, 0, 64'd0,    64'h1234, 64'd9);
    vecs[8]  = mk(8'h60, 8'h7E, 1'b0, 64'hDEAD, 64'd3,  1, 1, 4'hE, 4'h7, 4'hE, 4'hF, 0, 64'd0,    64'hDEAD, 64'h1234);
    vecs[9]  = mk(8'hC0, 8'h7E, 1'b1, 64'd1,    64'd2,  1, 1, 4'hE, 4'h7, 4'hF, 4'hF, 1, 64'hDEAD, 64'hDEAD, 64'h1234);
    vecs[10] = mk(8'h10, 8'h00, 1'b0, 64'd1,    64'd2,  1, 1, 4'hF, 4'hE, 4'hF, 4'hF, 1, 64'd0,    64'd0,    64'hDEAD);
    vecs[11] = mk(8'h10, 8'h00, 1'b0, 64'd1,    64'd2,  1, 0, 4'hE, 4'h7, 4'hF, 4'hF, 0, 64'd0,    64'd0,    64'd0);
    vecs[12] = mk(8'h90, 8'hFF, 1'b0, 64'h100,  64'd6,  1, 1, 4'h4, 4'h0, 4'h4, 4'hF, 0, 64'd77,   64'h100,  64'd0);
    vecs[13] = mk(8'h80, 8'hFF, 1'b0, 64'hF8,   64'd6,  1, 1, 4'h4, 4'h0, 4'h4, 4'hF, 0, 64'h100,  64'hF8,   64'd0);
    vecs[14] = mk(8'hB0, 8'h0F, 1'b0, 64'h108,  64'h55, 1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 0, 64'hF8,   64'h108,  64'h55);
    vecs[15] = mk(8'hD0, 8'h12, 1'b1, 64'd7,    64'd7,  1, 0, 4'h1, 4'h2, 4'hF, 4'hF, 1, 64'd0,    64'd0,    64'd0);
    vecs[16] = mk(8'h40, 8'h12, 1'b0, 64'h77,   64'h66, 1, 1, 4'h1, 4'h2, 4'hF, 4'hF, 0, 64'd0,    64'd0,    64'd5);

    reset = 1'b0; opcode = 8'h00; rArB = 8'hFF; cnd = 1'b0; valE = '0; valM = '0;
    wrEn = 1'b0; reEn = 1'b1; rd1 = 4'h0; rd2 = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int r = 0; r < 15; r++) begin
      rd1 = 4'(r); rd2 = 4'(14 - r);
      #1;
      chk("reset_rd1", r, val_read1, 64'd0);
      chk("reset_rd2", r, val_read2, 64'd0);
      chk("reset_err", r, {63'd0, regerr}, 64'd0);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      opcode = vecs[i].op; rArB = vecs[i].rarb; cnd = vecs[i].c;
      valE = vecs[i].ve; valM = vecs[i].vm; wrEn = vecs[i].we; reEn = vecs[i].re;
      rd1 = vecs[i].a1; rd2 = vecs[i].a2;
      #1;
      chk("dstE",   i, {60'd0, registernumber1}, {60'd0, vecs[i].e_dste});
      chk("dstM",   i, {60'd0, registernumber2}, {60'd0, vecs[i].e_dstm});
      chk("wdat1",  i, val_write1, vecs[i].ve);
      chk("wdat2",  i, val_write2, vecs[i].vm);
      chk("regerr", i, {63'd0, regerr}, {63'd0, vecs[i].e_err});
      chk("pre_rd1", i, val_read1, vecs[i].e_pre1);
      @(posedge clk);
      #1;
      chk("post_rd1", i, val_read1, vecs[i].e_post1);
      chk("post_rd2", i, val_read2, vecs[i].e_post2);
    end

    // Mid-cycle reset: clears immediately, discards a coinciding write, decode stays live.
    @(negedge clk);
    opcode = 8'hA0; rArB = 8'h30; valE = 64'h999; valM = '0; wrEn = 1'b1; reEn = 1'b1;
    rd1 = 4'h4; rd2 = 4'h3;
    #1;
    chk("pre_reset_rd1", 0, val_read1, 64'h108);
    reset = 1'b0;
    #1;
    chk("async_clr_rd1", 0, val_read1, 64'd0);
    chk("async_clr_rd2", 0, val_read2, 64'd0);
    chk("dstE_in_reset", 0, {60'd0, registernumber1}, 64'd4);
    @(posedge clk);
    #1;
    chk("write_blocked", 0, val_read1, 64'd0);
    rd1 = 4'h7; rd2 = 4'hE;
    #1;
    chk("clr_rd7", 0, val_read1, 64'd0);
    chk("clr_rdE", 0, val_read2, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    rd1 = 4'h4;
    @(posedge clk);
    #1;
    chk("post_release_wr", 0, val_read1, 64'h999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_regfile_writeback.md
Name: y86_regfile_writeback

Overview:
- Y86-64 write-back stage merged with the architectural register file.
- Decodes icode/ifun and rA/rB to pick up to two destination registers (E-port and M-port).
- Writes valE/valM into the 15-entry register file on the clock edge.
- Provides two combinational read ports with an error flag.
- Sits after the memory stage of the SEQ processor and feeds the decode stage's register reads.

Parameters:
- NREG, 15, number of architectural registers (IDs 0x0–0xE); ID 0xF means "no register".
- W, 64, data width.
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  in  1  system clock; writes occur on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  8  [7:4] icode, [3:0] ifun.
- rArB  in  8  [7:4] rA, [3:0] rB.
- cnd  in  1  condition result for cmovXX.
- valE  in  W  ALU result.
- valM  in  W  memory read data.
- wrEn  in  1  global write enable.
- reEn  in  1  read enable.
- registernumber1_read  in  4  read port 1 address.
- registernumber2_read  in  4  read port 2 address.
- registernumber1  out  4  E-port destination (dstE); 0xF if none.
- registernumber2  out  4  M-port destination (dstM); 0xF if none.
- val_write1  out  W  E-port write data (= valE).
- val_write2  out  W  M-port write data (= valM).
- val_read1  out  W  read port 1 data.
- val_read2  out  W  read port 2 data.
- regerr  out  1  error flag.

Behaviour:
Destination decode (combinational), by icode:
- 0x2 cmovXX: dstE = rB if cnd=1 or ifun=0, else 0xF; dstM = 0xF.
- 0x3 irmovq, 0x6 OPq: dstE = rB; dstM = 0xF.
- 0x5 mrmovq: dstE = 0xF; dstM = rA.
- 0x8 call, 0x9 ret, 0xA pushq: dstE = RSP_ID; dstM = 0xF.
- 0xB popq: dstE = RSP_ID; dstM = rA.
- 0x0, 0x1, 0x4, 0x7, 0xC–0xF: dstE = dstM = 0xF.

Write-back data and write timing:
- val_write1 = valE and val_write2 = valM, unconditionally and combinationally.
- Write happens on posedge clk when reset=1 and wrEn=1.
- reg[dstE] <= valE if dstE != 0xF; reg[dstM] <= valM if dstM != 0xF.
- If dstE == dstM (e.g. popq %rsp), the M-port wins: register receives valM.
- wrEn=0: no register changes.

Reads (combinational):
- When reEn=1, val_readN = reg[addrN] for addrN in 0x0–0xE, and 0 for addrN = 0xF.
- When reEn=0, both read outputs are 0.
- Read in the same cycle as a write returns the pre-edge value (no bypass).

regerr (combinational) is 1 when either:
- icode > 0xB, or
- reEn=1 and either read address = 0xF.
Otherwise regerr = 0.

Reset:
- reset=0 clears all 15 registers to 0 immediately, independent of clk.
- Writes are blocked while reset=0.
- A write coinciding with reset assertion is discarded.
- After reset, with reEn=1, valid read addresses return 0.
- Decode outputs stay purely combinational and are unaffected by reset.

Test Plan:
- Reset → all 15 registers read 0 with reEn=1; regerr=0 for valid addresses.
- pushq: opcode 0xA0, rArB 0x30, valE=1023, wrEn=1, one clk edge
  - registernumber1=4, registernumber2=15, val_write1=1023.
  - Reading reg 4 returns 1023; reg 3 unchanged (0).
- mrmovq: opcode 0x54, rArB 0x40, valM=120, wrEn=1
  - registernumber1=15, registernumber2=4, val_write2=120.
  - After edge, reg 4 = 120.
- popq %rsp: opcode 0xB0, rArB 0x4F, valE=8, valM=77, edge → reg 4 = 77 (M-port wins).
- cmovle not taken: opcode 0x21, cnd=0, rArB 0x12, valE=5 → dstE=15; reg 2 unchanged.
  - Then cnd=1 → reg 2 = 5 after edge.
- Errors and gating:
  - opcode 0xC0 → regerr=1.
  - reEn=1, read address 0xF → regerr=1, val_read=0.
  - wrEn=0 with irmovq → no write.
  - reset pulsed low mid-cycle after writes → registers return to 0 before the next edge.
